// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: opcodes, FSM states,
// instruction classes and the mux/trap codes driven onto the datapath.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_ILLEGAL,
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC
  } class_e;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_IMEM    = 2'b10;
  localparam logic [1:0] TC_DMEM    = 2'b11;

  function automatic class_e classify(input logic [6:0] op);
    case (op)
      OP_R:      return CL_R;
      OP_I:      return CL_I;
      OP_LOAD:   return CL_LOAD;
      OP_STORE:  return CL_STORE;
      OP_BRANCH: return CL_BRANCH;
      OP_JAL:    return CL_JAL;
      OP_JALR:   return CL_JALR;
      OP_LUI:    return CL_LUI;
      OP_AUIPC:  return CL_AUIPC;
      default:   return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Wait-state watchdog: counts cycles without an acknowledge and flags the
// cycle on which a further miss would exhaust the LIMIT-cycle budget.
module seq_timeout_ctr #(
  parameter int LIMIT = 16,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  // hit marks the LIMIT-th consecutive miss, so the trap lands after exactly LIMIT cycles
  assign hit = enable && (cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I datapath: steps FETCH/DECODE/EXEC/MEM/WB,
// drives enables and muxes, counts retired instructions and traps stickily.
module core_sequencer
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [6:0]       opc_q;
  logic [1:0]       tc_q, tc_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             to_hit, to_clear, to_en, in_wait;
  class_e           cls;

  assign cls = classify(opc_q);

  assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign to_en    = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
  assign to_clear = !in_wait || (state_d != state_q);

  seq_timeout_ctr #(.LIMIT(MEM_TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_en),
    .hit    (to_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      tc_q      <= TC_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      if (state_q == S_DECODE) opc_q <= opcode;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    tc_d      = tc_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
          tc_d    = TC_IMEM;
        end
      end
      // The IR only becomes valid here, so classification looks at the live opcode
      S_DECODE: begin
        if (classify(opcode) == CL_ILLEGAL) begin
          state_d = S_TRAP;
          tc_d    = TC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a_sel = (cls == CL_AUIPC);
        alu_b_sel = cls inside {CL_I, CL_LOAD, CL_STORE, CL_JALR, CL_AUIPC};
        case (cls)
          CL_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_BRANCH : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = S_MEM;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CL_STORE);
        if (dmem_ack) begin
          if (cls == CL_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit) begin
          state_d = S_TRAP;
          tc_d    = TC_DMEM;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (cls)
          CL_LOAD: wb_sel = WB_MEM;
          CL_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_BRANCH;
          end
          CL_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JALR;
          end
          CL_LUI:  wb_sel = WB_IMM;
          default: wb_sel = WB_ALU;
        endcase
      end
      default: state_d = S_TRAP;
    endcase

    // Reset drops any pending request in the same cycle it is asserted
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      retire    = 1'b0;
    end
  end

  assign state      = rst ? S_FETCH : state_q;
  assign trap       = !rst && (state_q == S_TRAP);
  assign trap_cause = rst ? TC_NONE : tc_q;
  assign instret    = rst ? '0 : instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: walks every instruction class, wait states,
// timeouts, illegal opcode trap and mid-transaction reset against hand-computed values.
module tb_core_sequencer;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, br_taken, imem_ack, dmem_ack;
  logic [6:0]  opcode;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start = 0;
  int exp_ret = 0;

  core_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .br_taken   (br_taken),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .alu_a_sel  (alu_a_sel),
    .alu_b_sel  (alu_b_sel),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state      (state),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic ia, input logic da, input logic bt, input logic [6:0] op);
    imem_ack = ia;
    dmem_ack = da;
    br_taken = bt;
    opcode   = op;
    #1;
  endtask

  // FETCH with immediate ack, then DECODE; returns with the FSM in EXEC
  task automatic fetchDecode(input logic [6:0] op);
    applyStimulus(1'b1, 1'b0, 1'b0, op);
    checkOutput("fetch_ir_we", 32'(ir_we), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, op);
    checkOutput("decode_state", 32'(state), 32'(S_DECODE));
    tick();
  endtask

  task automatic wbInstr(input string tag, input logic [6:0] op, input logic exp_a, input logic exp_b,
                         input logic [1:0] exp_wb, input logic [1:0] exp_pc);
    start = cyc;
    fetchDecode(op);
    checkOutput({tag, "_alu_a"}, 32'(alu_a_sel), 32'(exp_a));
    if (op != OP_JAL && op != OP_LUI) checkOutput({tag, "_alu_b"}, 32'(alu_b_sel), 32'(exp_b));
    tick();
    checkOutput({tag, "_wb_state"}, 32'(state), 32'(S_WB));
    checkOutput({tag, "_rf_we"}, 32'(rf_we), 32'd1);
    checkOutput({tag, "_wb_sel"}, 32'(wb_sel), 32'(exp_wb));
    checkOutput({tag, "_pc_we"}, 32'(pc_we), 32'd1);
    checkOutput({tag, "_pc_sel"}, 32'(pc_sel), 32'(exp_pc));
    tick();
    exp_ret++;
    checkOutput({tag, "_instret"}, instret, 32'(exp_ret));
    checkOutput({tag, "_cycles"}, 32'(cyc - start), 32'd4);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
    tick();
    tick();
    checkOutput("rst_state", 32'(state), 32'(S_FETCH));
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_trap", 32'(trap), 32'd0);
    checkOutput("rst_cause", 32'(trap_cause), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_imem_req", 32'(imem_req), 32'd1);

    // R-type
    wbInstr("rtype", OP_R, 1'b0, 1'b0, WB_ALU, PC_PLUS4);

    // Load with three wait cycles in MEM
    start = cyc;
    fetchDecode(OP_LOAD);
    checkOutput("load_alu_b", 32'(alu_b_sel), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, (i == 3), 1'b0, OP_LOAD);
      checkOutput("load_dmem_req", 32'(dmem_req), 32'd1);
      checkOutput("load_dmem_we", 32'(dmem_we), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, OP_LOAD);
    checkOutput("load_wb_sel", 32'(wb_sel), 32'(WB_MEM));
    checkOutput("load_rf_we", 32'(rf_we), 32'd1);
    tick();
    exp_ret++;
    checkOutput("load_instret", instret, 32'(exp_ret));
    checkOutput("load_cycles", 32'(cyc - start), 32'd8);

    // Store with immediate ack
    start = cyc;
    fetchDecode(OP_STORE);
    checkOutput("store_exec_rf_we", 32'(rf_we), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, OP_STORE);
    checkOutput("store_dmem_we", 32'(dmem_we), 32'd1);
    checkOutput("store_pc_we", 32'(pc_we), 32'd1);
    checkOutput("store_pc_sel", 32'(pc_sel), 32'(PC_PLUS4));
    checkOutput("store_rf_we", 32'(rf_we), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, OP_STORE);
    exp_ret++;
    checkOutput("store_instret", instret, 32'(exp_ret));
    checkOutput("store_cycles", 32'(cyc - start), 32'd4);

    // Branch taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      start = cyc;
      fetchDecode(OP_BRANCH);
      applyStimulus(1'b0, 1'b0, t[0], OP_BRANCH);
      checkOutput("br_pc_we", 32'(pc_we), 32'd1);
      checkOutput("br_pc_sel", 32'(pc_sel), (t == 1) ? 32'(PC_BRANCH) : 32'(PC_PLUS4));
      checkOutput("br_rf_we", 32'(rf_we), 32'd0);
      tick();
      exp_ret++;
      checkOutput("br_instret", instret, 32'(exp_ret));
      checkOutput("br_cycles", 32'(cyc - start), 32'd3);
      checkOutput("br_state", 32'(state), 32'(S_FETCH));
    end

    wbInstr("jal", OP_JAL, 1'b0, 1'b0, WB_PC4, PC_BRANCH);
    wbInstr("jalr", OP_JALR, 1'b0, 1'b1, WB_PC4, PC_JALR);
    wbInstr("lui", OP_LUI, 1'b0, 1'b0, WB_IMM, PC_PLUS4);
    wbInstr("auipc", OP_AUIPC, 1'b1, 1'b1, WB_ALU, PC_PLUS4);
    wbInstr("itype", OP_I, 1'b0, 1'b1, WB_ALU, PC_PLUS4);

    // Reset in the middle of a load wait
    fetchDecode(OP_LOAD);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, OP_LOAD);
    tick();
    tick();
    checkOutput("midmem_state", 32'(state), 32'(S_MEM));
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, OP_LOAD);
    checkOutput("midmem_req_drop", 32'(dmem_req), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, OP_R);
    exp_ret = 0;
    checkOutput("midmem_rst_state", 32'(state), 32'(S_FETCH));
    checkOutput("midmem_rst_instret", instret, 32'd0);
    checkOutput("midmem_rst_imem_req", 32'(imem_req), 32'd1);

    // imem ack on the last allowed cycle still wins over the timeout
    repeat (15) tick();
    checkOutput("imem_edge_state", 32'(state), 32'(S_FETCH));
    applyStimulus(1'b1, 1'b0, 1'b0, OP_LUI);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, OP_LUI);
    checkOutput("imem_edge_decode", 32'(state), 32'(S_DECODE));
    checkOutput("imem_edge_trap", 32'(trap), 32'd0);
    tick();
    tick();
    tick();
    exp_ret++;
    checkOutput("imem_edge_instret", instret, 32'(exp_ret));

    // dmem timeout on a store
    fetchDecode(OP_STORE);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, OP_STORE);
    repeat (15) tick();
    checkOutput("dmem_to_wait_state", 32'(state), 32'(S_MEM));
    tick();
    checkOutput("dmem_to_state", 32'(state), 32'(S_TRAP));
    checkOutput("dmem_to_cause", 32'(trap_cause), 32'(TC_DMEM));
    checkOutput("dmem_to_req", 32'(dmem_req), 32'd0);
    checkOutput("dmem_to_instret", instret, 32'(exp_ret));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ret = 0;

    // imem timeout
    applyStimulus(1'b0, 1'b0, 1'b0, OP_R);
    repeat (15) tick();
    checkOutput("imem_to_wait_req", 32'(imem_req), 32'd1);
    tick();
    checkOutput("imem_to_state", 32'(state), 32'(S_TRAP));
    checkOutput("imem_to_trap", 32'(trap), 32'd1);
    checkOutput("imem_to_cause", 32'(trap_cause), 32'(TC_IMEM));
    checkOutput("imem_to_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, OP_R);
    tick();
    checkOutput("imem_to_sticky", 32'(state), 32'(S_TRAP));

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, OP_R);
    tick();
    rst = 1'b0;

    // Illegal opcode
    fetchDecode(7'h7F);
    checkOutput("illegal_state", 32'(state), 32'(S_TRAP));
    checkOutput("illegal_trap", 32'(trap), 32'd1);
    checkOutput("illegal_cause", 32'(trap_cause), 32'(TC_ILLEGAL));
    applyStimulus(1'b1, 1'b1, 1'b1, OP_R);
    checkOutput("illegal_imem_req", 32'(imem_req), 32'd0);
    checkOutput("illegal_pc_we", 32'(pc_we), 32'd0);
    tick();
    tick();
    checkOutput("illegal_sticky_trap", 32'(trap), 32'd1);
    checkOutput("illegal_sticky_cause", 32'(trap_cause), 32'(TC_ILLEGAL));
    checkOutput("illegal_instret", instret, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
